incubator: RTL and testbench

INCUBATOR -- requirements
Module: incubator

---
 rtl/incubator.sv | 114 +++++++++++
 tb/tb_incubator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/incubator.sv
// Incubator climate controller: Moore FSM selects heating or staged cooling from the measured temperature.
// Optional INCUBATOR_ALARM_EN adds a registered out-of-range Alarm output.
module incubator #(
    parameter logic [7:0] T_HEAT_ON  = 8'd15,
    parameter logic [7:0] T_HEAT_OFF = 8'd30,
    parameter logic [7:0] T_COOL_ON  = 8'd35,
    parameter logic [7:0] T_COOL_OFF = 8'd25,
    parameter logic [7:0] T_MID      = 8'd40,
    parameter logic [7:0] T_HIGH     = 8'd45
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] T,
    output logic       Heater,
    output logic       Cooler,
    output logic [7:0] CRS
`ifdef INCUBATOR_ALARM_EN
    ,
    output logic       Alarm
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAT  = 3'd1,
        ST_COOL1 = 3'd2,
        ST_COOL2 = 3'd3,
        ST_COOL3 = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_heater;
    logic       r_cooler;
    logic [7:0] r_crs;
    logic [7:0] w_crs_next;

    // Every move sits in a taken-if branch, so an unknown T falls through to hold.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (T < T_HEAT_ON)
                    w_next = ST_HEAT;
                else if (T > T_COOL_ON)
                    w_next = ST_COOL1;
            end
            ST_HEAT: begin
                if (T >= T_HEAT_OFF)
                    w_next = ST_IDLE;
            end
            ST_COOL1: begin
                if (T > T_MID)
                    w_next = ST_COOL2;
                else if (T < T_COOL_OFF)
                    w_next = ST_IDLE;
            end
            ST_COOL2: begin
                if (T > T_HIGH)
                    w_next = ST_COOL3;
                else if (T < T_COOL_ON)
                    w_next = ST_COOL1;
            end
            ST_COOL3: begin
                if (T < T_MID)
                    w_next = ST_COOL2;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_crs_next = 8'd0;
        case (w_next)
            ST_COOL1: w_crs_next = 8'd4;
            ST_COOL2: w_crs_next = 8'd6;
            ST_COOL3: w_crs_next = 8'd8;
            default:  w_crs_next = 8'd0;
        endcase
    end

    // Outputs are registered alongside the state, so they always match the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_heater <= 1'b0;
            r_cooler <= 1'b0;
            r_crs    <= 8'd0;
        end else begin
            r_state  <= w_next;
            r_heater <= (w_next == ST_HEAT);
            r_cooler <= (w_next == ST_COOL1) || (w_next == ST_COOL2) || (w_next == ST_COOL3);
            r_crs    <= w_crs_next;
        end
    end

    assign Heater = r_heater;
    assign Cooler = r_cooler;
    assign CRS    = r_crs;

`ifdef INCUBATOR_ALARM_EN
    logic r_alarm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_alarm <= 1'b0;
        else
            r_alarm <= (T > 8'd55) || (T < 8'd5);
    end

    assign Alarm = r_alarm;
`endif

endmodule

// File: tb/tb_incubator.sv
// Directed bench for incubator: a vector table walked edge by edge, plus reset corner sequences.
module tb_incubator;

    logic       clk;
    logic       reset;
    logic [7:0] T;
    logic       Heater;
    logic       Cooler;
    logic [7:0] CRS;
`ifdef INCUBATOR_ALARM_EN
    logic       Alarm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    incubator dut (
        .clk    (clk),
        .reset  (reset),
        .T      (T),
        .Heater (Heater),
        .Cooler (Cooler),
        .CRS    (CRS)
`ifdef INCUBATOR_ALARM_EN
        ,
        .Alarm  (Alarm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] t;
        logic       heater;
        logic       cooler;
        logic [7:0] crs;
        logic       alarm;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] t, input logic h, input logic c,
                                input logic [7:0] s, input logic a);
        vec_t v;
        v.t = t; v.heater = h; v.cooler = c; v.crs = s; v.alarm = a;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic h, input logic c, input logic [7:0] s);
        check({name, ".Heater"}, {7'd0, Heater}, {7'd0, h});
        check({name, ".Cooler"}, {7'd0, Cooler}, {7'd0, c});
        check({name, ".CRS"}, CRS, s);
        check({name, ".excl"}, {7'd0, Heater & Cooler}, 8'd0);
    endtask

    task automatic step(input logic [7:0] t);
        T = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T, Heater, Cooler, CRS, Alarm after the edge; one state move per row
        vecs[0]  = mk(8'd10,  1, 0, 8'd0, 0);  // IDLE -> HEAT
        vecs[1]  = mk(8'd29,  1, 0, 8'd0, 0);  // HEAT holds
        vecs[2]  = mk(8'd30,  0, 0, 8'd0, 0);  // -> IDLE
        vecs[3]  = mk(8'd35,  0, 0, 8'd0, 0);  // IDLE holds
        vecs[4]  = mk(8'd36,  0, 1, 8'd4, 0);  // -> COOL1
        vecs[5]  = mk(8'd25,  0, 1, 8'd4, 0);  // COOL1 holds
        vecs[6]  = mk(8'd24,  0, 0, 8'd0, 0);  // -> IDLE
        vecs[7]  = mk(8'd0,   1, 0, 8'd0, 1);  // -> HEAT
        vecs[8]  = mk(8'd60,  0, 0, 8'd0, 1);  // -> IDLE (never straight to COOL)
        vecs[9]  = mk(8'd60,  0, 1, 8'd4, 1);  // -> COOL1
        vecs[10] = mk(8'd60,  0, 1, 8'd6, 1);  // -> COOL2
        vecs[11] = mk(8'd60,  0, 1, 8'd8, 1);  // -> COOL3
        vecs[12] = mk(8'd255, 0, 1, 8'd8, 1);  // COOL3 holds
        vecs[13] = mk(8'd40,  0, 1, 8'd8, 0);  // COOL3 holds at T_MID
        vecs[14] = mk(8'd18,  0, 1, 8'd6, 0);  // -> COOL2
        vecs[15] = mk(8'd18,  0, 1, 8'd4, 0);  // -> COOL1
        vecs[16] = mk(8'd18,  0, 0, 8'd0, 0);  // -> IDLE
        vecs[17] = mk(8'd18,  0, 0, 8'd0, 0);  // IDLE holds
        vecs[18] = mk(8'd14,  1, 0, 8'd0, 0);  // -> HEAT
        vecs[19] = mk(8'd255, 0, 0, 8'd0, 1);  // -> IDLE
        vecs[20] = mk(8'd41,  0, 1, 8'd4, 0);  // -> COOL1
        vecs[21] = mk(8'd40,  0, 1, 8'd4, 0);  // COOL1 holds at T_MID
        vecs[22] = mk(8'd41,  0, 1, 8'd6, 0);  // -> COOL2
        vecs[23] = mk(8'd45,  0, 1, 8'd6, 0);  // COOL2 holds at T_HIGH
        vecs[24] = mk(8'd35,  0, 1, 8'd6, 0);  // COOL2 holds at T_COOL_ON
        vecs[25] = mk(8'd34,  0, 1, 8'd4, 0);  // -> COOL1
        vecs[26] = mk(8'd41,  0, 1, 8'd6, 0);  // -> COOL2
        vecs[27] = mk(8'd46,  0, 1, 8'd8, 0);  // -> COOL3
        vecs[28] = mk(8'd39,  0, 1, 8'd6, 0);  // -> COOL2

        reset = 1'b0;
        T     = 8'd10;
        #2;
        check_outs("reset_async", 0, 0, 8'd0);
        @(posedge clk);
        #1;
        check_outs("reset_held_edge", 0, 0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outs("reset_release", 0, 0, 8'd0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].t);
            check_outs($sformatf("vec%0d", i), vecs[i].heater, vecs[i].cooler, vecs[i].crs);
`ifdef INCUBATOR_ALARM_EN
            check($sformatf("vec%0d.Alarm", i), {7'd0, Alarm}, {7'd0, vecs[i].alarm});
`endif
            $display("vec %0d T=%0d Heater=%0d Cooler=%0d CRS=%0d", i, vecs[i].t, Heater, Cooler, CRS);
        end

        // Reset pulse while in COOL2: outputs clear with no clock edge.
        @(negedge clk);
        check_outs("pre_reset_cool2", 0, 1, 8'd6);
        reset = 1'b0;
        #1;
        check_outs("reset_in_cool2", 0, 0, 8'd0);
        #1;
        reset = 1'b1;
        step(8'd20);
        check_outs("restart_idle_hold", 0, 0, 8'd0);
        step(8'd10);
        check_outs("restart_heat", 1, 0, 8'd0);
        $display("reset pulse in COOL2 then restart: Heater=%0d Cooler=%0d CRS=%0d", Heater, Cooler, CRS);

        // Reset pulse while in HEAT.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("reset_in_heat", 0, 0, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        step(8'd10);
        check_outs("heat_after_reset", 1, 0, 8'd0);
        $display("reset pulse in HEAT then restart: Heater=%0d Cooler=%0d CRS=%0d", Heater, Cooler, CRS);

`ifdef INCUBATOR_ALARM_EN
        step(8'd60);
        check("alarm_set", {7'd0, Alarm}, 8'd1);
        step(8'd30);
        check("alarm_clear", {7'd0, Alarm}, 8'd0);
        $display("alarm sequence: Alarm=%0d", Alarm);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
